// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters/FIFO flag and the round-robin arbiter.
// The master side drives requests and the full flag; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        full;
  logic                        wr_en;
  logic [DATA_WIDTH-1:0]       din;
  logic [GID_W-1:0]            grant_id;
  logic                        busy;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr_en, din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr_en, din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port between N_REQ requesters.
// Each grant lasts up to MAX_BURST writes; an IDLE bubble separates consecutive grants.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic              wr_clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  arb
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [GID_W-1:0] LAST_ID   = GID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic [GID_W:0]      pick;
  logic [GID_W-1:0]    next_id;
  logic                in_grant;
  logic                gnt_valid;
  logic                xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  // Modulo-N increment that also works when N_REQ is not a power of two.
  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Returns {found, index} of the first valid bit at or after ptr, circularly.
  function automatic logic [GID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [GID_W-1:0] ptr);
    logic             found;
    logic [GID_W-1:0] idx;
    logic [GID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = wrap_inc(cand);
    end
    return {found, idx};
  endfunction

  always_comb begin
    pick      = rr_pick(arb.req_valid, rr_ptr_q);
    next_id   = wrap_inc(grant_id_q);
    in_grant  = (state_q == GRANT) && !rst;
    gnt_valid = arb.req_valid[grant_id_q];
    xfer      = in_grant && gnt_valid && !arb.full;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        sel_data = arb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state: a full stall falls through every branch and holds all state.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick[GID_W]) begin
          state_d     = GRANT;
          grant_id_d  = pick[GID_W-1:0];
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (burst_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_id;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (!gnt_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Outputs are forced low during reset so a reset cycle can never write.
  always_comb begin
    arb.req_ready = '0;
    if (xfer) begin
      arb.req_ready[grant_id_q] = 1'b1;
    end
    arb.wr_en    = xfer;
    arb.din      = in_grant ? sel_data : '0;
    arb.busy     = in_grant;
    arb.grant_id = rst ? '0 : grant_id_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a random run against an
// abstract round-robin model that tracks who holds the grant and how many writes it made.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int GW = $clog2(N);

  logic wr_clk = 1'b0;
  logic rst;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .MAX_BURST(MB)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .arb    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;

  // Reference: who owns the grant (if anyone), writes made in it, next search start.
  bit m_busy = 1'b0;
  int m_gid  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (bus.req_valid[(m_ptr + k) % N]) begin
          m_busy = 1'b1;
          m_gid  = (m_ptr + k) % N;
          m_cnt  = 0;
          break;
        end
      end
    end else if (bus.req_valid[m_gid] && !bus.full) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 1'b0;
        m_ptr  = (m_gid + 1) % N;
      end
    end else if (!bus.req_valid[m_gid]) begin
      m_busy = 1'b0;
      m_ptr  = (m_gid + 1) % N;
    end
  endtask

  task automatic cycle();
    @(posedge wr_clk);
    model_edge();
    @(negedge wr_clk);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    bus.req_data[i*DW +: DW] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.full = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.full = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 8'hA0 + 8'(i));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs c=%0d: wr_en=%b ready=%b busy=%b gid=%0d, required 0/0000/0/0",
                 c, bus.wr_en, bus.req_ready, bus.busy, bus.grant_id);
      end
      cycle();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b wr_en=%b, required 0/0", bus.busy, bus.wr_en);
    end
    cycle();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.req_ready !== 4'b0001 || bus.din !== 8'hA0) begin
      failures++;
      $display("FAIL reset_first_grant: busy=%b gid=%0d ready=%b din=%h, required 1/0/0001/a0",
               bus.busy, bus.grant_id, bus.req_ready, bus.din);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_reset();
    bus.req_valid = 4'b0100;
    set_word(2, words[0]);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: busy=%b, required 0", bus.busy);
    end
    cycle();
    for (int w = 0; w < 3; w++) begin
      set_word(2, words[w]);
      #1;
      checks++;
      if (bus.grant_id !== 2'd2 || bus.wr_en !== 1'b1 || bus.din !== words[w] || bus.req_ready !== 4'b0100) begin
        failures++;
        $display("FAIL single_write%0d: gid=%0d wr_en=%b din=%h ready=%b, required 2/1/%h/0100",
                 w, bus.grant_id, bus.wr_en, bus.din, bus.req_ready, words[w]);
      end
      cycle();
    end
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_drop: wr_en=%b busy=%b, required 0/1", bus.wr_en, bus.busy);
    end
    cycle();
    bus.req_valid = 4'b1001;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release: busy=%b, required 0", bus.busy);
    end
    cycle();
    #1;
    checks++;
    if (bus.grant_id !== 2'd3 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_next_ptr: gid=%0d busy=%b, required 3/1", bus.grant_id, bus.busy);
    end
    bus.req_valid = '0;
    cycle();
  endtask

  task automatic test_contention();
    int writes = 0;
    int egid;
    bit ewr;
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, 8'h50 + 8'(i));
    for (int c = 0; c < 25; c++) begin
      #1;
      ewr  = (c % 5) != 0;
      egid = (c / 5) % N;
      if (c < 20 && bus.wr_en === 1'b1) writes++;
      checks++;
      if (bus.wr_en !== ewr || bus.busy !== ewr ||
          (ewr && (bus.grant_id !== GW'(egid) || bus.din !== 8'h50 + 8'(egid)))) begin
        failures++;
        $display("FAIL contention c=%0d: wr_en=%b busy=%b gid=%0d din=%h, required wr_en=%b gid=%0d",
                 c, bus.wr_en, bus.busy, bus.grant_id, bus.din, ewr, egid);
      end
      cycle();
    end
    checks++;
    if (writes != 16) begin
      failures++;
      $display("FAIL contention_count: writes=%0d in 20 cycles, required 16", writes);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req_valid = 4'b0110;
    set_word(1, 8'h61);
    set_word(2, 8'h62);
    cycle();
    for (int c = 1; c <= 11; c++) begin
      bus.full = (c >= 3 && c <= 7);
      #1;
      checks++;
      if (c <= 2 || c == 8 || c == 9) begin
        if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd1 || bus.req_ready !== 4'b0010) begin
          failures++;
          $display("FAIL stall_write c=%0d: wr_en=%b gid=%0d ready=%b, required 1/1/0010",
                   c, bus.wr_en, bus.grant_id, bus.req_ready);
        end
      end else if (c <= 7) begin
        if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold c=%0d: wr_en=%b ready=%b gid=%0d busy=%b, required 0/0000/1/1",
                   c, bus.wr_en, bus.req_ready, bus.grant_id, bus.busy);
        end
      end else if (c == 10) begin
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_release: busy=%b wr_en=%b, required 0/0", bus.busy, bus.wr_en);
        end
      end else begin
        if (bus.grant_id !== 2'd2 || bus.wr_en !== 1'b1 || bus.din !== 8'h62) begin
          failures++;
          $display("FAIL stall_next: gid=%0d wr_en=%b din=%h, required 2/1/62",
                   bus.grant_id, bus.wr_en, bus.din);
        end
      end
      cycle();
    end
    bus.req_valid = '0;
    bus.full = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.req_valid = 4'b1001;
    bus.full = 1'b1;
    set_word(0, 8'h70);
    set_word(3, 8'h73);
    cycle();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_grant: busy=%b gid=%0d wr_en=%b, required 1/0/0", bus.busy, bus.grant_id, bus.wr_en);
    end
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL withdraw_nowrite: wr_en=%b ready=%b, required 0/0000", bus.wr_en, bus.req_ready);
    end
    cycle();
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_release: busy=%b, required 0", bus.busy);
    end
    cycle();
    bus.full = 1'b0;
    #1;
    checks++;
    if (bus.grant_id !== 2'd3 || bus.wr_en !== 1'b1 || bus.din !== 8'h73) begin
      failures++;
      $display("FAIL withdraw_next: gid=%0d wr_en=%b din=%h, required 3/1/73", bus.grant_id, bus.wr_en, bus.din);
    end
    bus.req_valid = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b1000;
    for (int i = 0; i < N; i++) set_word(i, 8'h80 + 8'(i));
    cycle();
    #1;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd3) begin
      failures++;
      $display("FAIL midrst_first: wr_en=%b gid=%0d, required 1/3", bus.wr_en, bus.grant_id);
    end
    cycle();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_cycle: wr_en=%b ready=%b busy=%b, required 0/0000/0", bus.wr_en, bus.req_ready, bus.busy);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
      failures++;
      $display("FAIL midrst_idle: busy=%b gid=%0d, required 0/0", bus.busy, bus.grant_id);
    end
    cycle();
    #1;
    checks++;
    if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1 || bus.din !== 8'h80) begin
      failures++;
      $display("FAIL midrst_regrant: gid=%0d busy=%b din=%h, required 0/1/80", bus.grant_id, bus.busy, bus.din);
    end
    bus.req_valid = '0;
    cycle();
  endtask

  task automatic test_random();
    logic [N-1:0]  last_ready = '0;
    logic [N-1:0]  e_ready;
    logic [DW-1:0] e_din;
    bit            e_x, e_busy;
    int            e_gid;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_ready[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom % 3) != 0;
          set_word(i, 8'($urandom));
        end else if (bus.full && ($urandom % 6) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.full = ($urandom % 5) == 0;
      rst = ($urandom % 80) == 0;
      #1;
      e_x     = !rst && m_busy && bus.req_valid[m_gid] && !bus.full;
      e_busy  = !rst && m_busy;
      e_gid   = rst ? 0 : m_gid;
      e_ready = e_x ? (4'b0001 << m_gid) : 4'b0000;
      e_din   = e_busy ? bus.req_data[m_gid*DW +: DW] : 8'h00;
      checks++;
      if (bus.wr_en !== e_x || bus.req_ready !== e_ready || bus.busy !== e_busy ||
          bus.grant_id !== GW'(e_gid) || bus.din !== e_din) begin
        failures++;
        $display("FAIL random c=%0d: wr_en=%b ready=%b busy=%b gid=%0d din=%h, required %b/%b/%b/%0d/%h",
                 c, bus.wr_en, bus.req_ready, bus.busy, bus.grant_id, bus.din,
                 e_x, e_ready, e_busy, e_gid, e_din);
      end
      last_ready = e_ready;
      cycle();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    bus.full = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.full = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_full_stall();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of `async_fifo` between `N_REQ` requesters in the `wr_clk` domain. Each requester offers words with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's `wr_en`/`din`, honouring `full`. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width; matches the FIFO.
- `N_REQ`, 4, number of requesters; must be ≥ 2 (any value, not only powers of two).
- `MAX_BURST`, 4, maximum consecutive writes per grant; must be ≥ 1.

Ports:
- `wr_clk`  in  1  single clock, the FIFO write clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  bit i set: requester i offers a word.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  N_REQ  bit i set: requester i's word is written this cycle.
- `full`  in  1  FIFO full flag, write-domain.
- `wr_en`  out  1  FIFO write enable.
- `din`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `busy`  out  1  high in GRANT state.

## Operation
- Registered state:
  - FSM {IDLE, GRANT}.
  - `grant_id`.
  - `rr_ptr` (0..N_REQ-1).
  - `burst_cnt` (0..MAX_BURST-1).
- IDLE:
  - If any `req_valid` bit is set, pick the first set bit searching circularly from `rr_ptr` upward.
  - Register the pick into `grant_id`, clear `burst_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, transfer condition: `xfer = req_valid[grant_id] & ~full`.
- Outputs are combinational from registered state:
  - `wr_en = xfer`.
  - `req_ready[grant_id] = xfer`; all other `req_ready` bits are 0.
  - `din = req_data[grant_id]` in GRANT, else 0.
  - All three are forced 0 outside GRANT and whenever `rst` = 1.
- On `xfer`, `burst_cnt` increments.
- Release from GRANT to IDLE, with `rr_ptr <= (grant_id+1) mod N_REQ`, on either:
  - (a) `xfer` with `burst_cnt == MAX_BURST-1`;
  - (b) `req_valid[grant_id] == 0`, with no write that cycle.
- `full` stall: while `full` = 1 the grant is held indefinitely, `burst_cnt` holds, and no write occurs. There is no timeout.
- Requester protocol: hold `req_valid` and data stable until `req_ready`. Dropping `req_valid` while stalled is legal and releases the grant per (b).
- `rr_ptr` wrap: N_REQ-1 + 1 → 0.
- A requester not granted never sees `req_ready` high.
- Reset:
  - All registers clear: state IDLE, `grant_id` 0, `rr_ptr` 0, `burst_cnt` 0.
  - Outputs: `wr_en` 0, `req_ready` 0, `din` 0, `busy` 0, `grant_id` 0.
  - Reset mid-burst discards the grant. No write occurs in the reset cycle.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k is granted after edge k; the first write is in the cycle following edge k, at earliest.
- One IDLE bubble cycle after every release; no back-to-back grants.
- Throughput under full contention: MAX_BURST writes per MAX_BURST+1 cycles.
- Write occurs at the `wr_clk` edge where `wr_en` = 1. `full` must be the FIFO's current write-side flag.
- Combinational paths: `full`/`req_valid` → `wr_en`/`req_ready`; `req_data` → `din`.
- With `MAX_BURST` = 1 the block is pure per-word round-robin.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req_valid`=4'b1111 and `full`=0 → `wr_en`=0, `req_ready`=0, `busy`=0, `grant_id`=0 throughout; first grant to requester 0 one cycle after `rst` falls.
- Single requester: requester 2 offers 0x11, 0x22, 0x33, then drops valid → `grant_id`=2 one cycle later; `wr_en` high 3 consecutive cycles with `din` 0x11, 0x22, 0x33; return to IDLE; next grant search starts at 3.
- Contention: all 4 requesters valid continuously, `MAX_BURST`=4 → grant order 0,1,2,3,0; each grant gives exactly 4 writes then 1 idle cycle; 16 writes in 20 cycles.
- Full stall: requester 1 bursting; `full`=1 after its 2nd write for 5 cycles → `wr_en`=0 and `req_ready`=0 for those 5 cycles, `grant_id` stays 1; 2 more writes after `full` falls, then release to requester 2.
- Withdraw while stalled: `full`=1 and requester 0 drops `req_valid` → release next edge; with requester 3 valid, requester 3 is granted after the IDLE cycle.
- Reset mid-burst: `rst` pulsed for 1 cycle after requester 3's 1st write → no write in the reset cycle; IDLE with `rr_ptr`=0; with all valid, next grant goes to requester 0.
